p2s_burst_scheduler: RTL

Round-robin scheduler that shares the single parallel-to-serial converter among four byte-wide requesters. It sequences the converter's `data_in`/`valid_in` inputs on the byte clock. After reset it first runs a mandatory idle (comma) training window. It then grants bursts of up to MAX_BURST bytes, each preceded by a header byte identifying the owner. It sits directly upstream of the serializer; `clk` is the byte clock, and the serializer's `clk_8f` is not used here.

---
 rtl/p2s_burst_scheduler_if.sv | 21 ++
 rtl/p2s_burst_scheduler.sv | 126 ++++++++++++
 2 files changed

// File: rtl/p2s_burst_scheduler_if.sv
// Requester-side and serializer-side signals of the burst scheduler.
// The master modport is the requesters' view; the slave modport is the scheduler's view.
interface p2s_burst_scheduler_if;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  data_out;
  logic        valid_out;
  logic [1:0]  grant_id;
  logic        busy;

  modport master (
    output req_valid, req_data,
    input  req_ready, data_out, valid_out, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, data_out, valid_out, grant_id, busy
  );
endinterface

// File: rtl/p2s_burst_scheduler.sv
// Round-robin burst scheduler feeding a shared parallel-to-serial converter.
// It runs an idle training window after reset, then sends header-prefixed bursts.
module p2s_burst_scheduler #(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned INIT_IDLE = 8,
  parameter logic [3:0]  HDR_TAG   = 4'hA
) (
  input logic                    clk,
  input logic                    reset_L,
  p2s_burst_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {StInit, StIdle, StData} state_e;

  state_e      state_q, state_d;
  logic [7:0]  idle_cnt_q, idle_cnt_d;
  logic [3:0]  burst_cnt_q, burst_cnt_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic [1:0]  grant_q, grant_d;
  logic        busy_q, busy_d;
  logic [3:0]  ready;

  logic [3:0][7:0] req_bytes;
  logic            win_found;
  logic [1:0]      win_idx;
  logic            idle_done;
  logic            last_byte;
  logic            grant_valid;

  assign req_bytes   = bus.req_data;
  assign idle_done   = (idle_cnt_q == 8'(INIT_IDLE - 1));
  assign last_byte   = (burst_cnt_q == 4'(MAX_BURST - 1));
  assign grant_valid = bus.req_valid[grant_q];

  // Rotating priority: scan from ptr_q upward, wrapping 3 -> 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int i = 0; i < 4; i++) begin
      if (!win_found && bus.req_valid[ptr_q + 2'(i)]) begin
        win_found = 1'b1;
        win_idx   = ptr_q + 2'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q     <= StInit;
      idle_cnt_q  <= 8'd0;
      burst_cnt_q <= 4'd0;
      ptr_q       <= 2'd0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      grant_q     <= 2'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      ptr_q       <= ptr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit:  if (idle_done) state_d = StIdle;
      StIdle:  if (win_found) state_d = StData;
      StData:  if (!grant_valid || last_byte) state_d = StIdle;
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    idle_cnt_d  = idle_cnt_q;
    burst_cnt_d = burst_cnt_q;
    ptr_d       = ptr_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    grant_d     = grant_q;
    busy_d      = busy_q;
    ready       = 4'b0000;
    unique case (state_q)
      StInit: idle_cnt_d = idle_cnt_q + 8'd1;
      StIdle: begin
        if (win_found) begin
          data_d      = {HDR_TAG, 2'b00, win_idx};
          valid_d     = 1'b1;
          grant_d     = win_idx;
          busy_d      = 1'b1;
          burst_cnt_d = 4'd0;
        end else begin
          busy_d = 1'b0;
        end
      end
      StData: begin
        ready[grant_q] = 1'b1;
        if (grant_valid) begin
          data_d      = req_bytes[grant_q];
          valid_d     = 1'b1;
          burst_cnt_d = burst_cnt_q + 4'd1;
          if (last_byte) ptr_d = grant_q + 2'd1;
        end else begin
          // Early end: busy drops now; a full burst keeps busy for a back-to-back header.
          busy_d = 1'b0;
          ptr_d  = grant_q + 2'd1;
        end
      end
      default: ;
    endcase
  end

  assign bus.req_ready = ready;
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = busy_q;

endmodule
